// File: rtl/hpf_pkg.sv
// hpf_pkg: shared constants and helpers for the time-multiplexed high-pass filter.
//   HPF_WIDTH / HPF_SCALE / HPF_CHANNELS : default configuration
//   HPF_ACCW      : accumulator width for t = y + x - x_prev (no overflow)
//   HPF_PROD_W    : width of t * alpha
//   HPF_ALPHA_ONE : alpha value representing 1.0
//   HPF_SMAX/SMIN : output sample range
//   sat_round()   : round-half-up, arithmetic shift and clip of a product
package hpf_pkg;

  localparam int unsigned HPF_WIDTH     = 10;
  localparam int unsigned HPF_SCALE     = 15;
  localparam int unsigned HPF_CHANNELS  = 4;
  localparam int unsigned HPF_ALPHA_RST = 30831;  // ~0.9409 in Q1.15

  localparam int unsigned HPF_ACCW      = HPF_WIDTH + 2;
  localparam int unsigned HPF_PROD_W    = HPF_ACCW + HPF_SCALE + 1;
  localparam int unsigned HPF_ALPHA_ONE = 1 << HPF_SCALE;
  localparam int          HPF_SMAX      = (1 << (HPF_WIDTH - 1)) - 1;
  localparam int          HPF_SMIN      = -(1 << (HPF_WIDTH - 1));

  typedef struct packed {
    logic signed [31:0] y;
    logic               sat;
  } sat_res_t;

  // Products are handled at 64 bits so the helper serves any WIDTH/SCALE that fits.
  function automatic sat_res_t sat_round(input logic signed [63:0] p,
                                         input int unsigned width,
                                         input int unsigned scale);
    logic signed [63:0] r;
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    sat_res_t           res;
    r   = (p + (64'sd1 <<< (scale - 1))) >>> scale;
    mx  = (64'sd1 <<< (width - 1)) - 64'sd1;
    mn  = -(64'sd1 <<< (width - 1));
    res.sat = 1'b0;
    if (r > mx) begin
      r       = mx;
      res.sat = 1'b1;
    end else if (r < mn) begin
      r       = mn;
      res.sat = 1'b1;
    end
    res.y = r[31:0];
    return res;
  endfunction

endpackage

// File: rtl/hpf_tdm_if.sv
// hpf_tdm_if: streaming bundle for hpf_tdm.
//   s_*   : input sample stream (valid/ready, channel tag, data)
//   cfg_* : per-sample alpha and bypass, captured at accept
//   clr_* : per-channel state clear request
//   m_*   : output sample stream (valid/ready, channel tag, data, saturation flag)
// Modports: slave = filter side, master = producer/consumer side.
interface hpf_tdm_if #(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned SCALE    = 15,
  parameter int unsigned CHANNELS = 4
) ();

  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                    s_valid;
  logic                    s_ready;
  logic [CH_W-1:0]         s_ch;
  logic signed [WIDTH-1:0] s_data;
  logic [SCALE:0]          cfg_alpha;
  logic                    cfg_bypass;
  logic                    clr_valid;
  logic [CH_W-1:0]         clr_ch;
  logic                    m_valid;
  logic                    m_ready;
  logic [CH_W-1:0]         m_ch;
  logic signed [WIDTH-1:0] m_data;
  logic                    m_sat;

  modport slave (
    input  s_valid, s_ch, s_data, cfg_alpha, cfg_bypass, clr_valid, clr_ch, m_ready,
    output s_ready, m_valid, m_ch, m_data, m_sat
  );

  modport master (
    output s_valid, s_ch, s_data, cfg_alpha, cfg_bypass, clr_valid, clr_ch, m_ready,
    input  s_ready, m_valid, m_ch, m_data, m_sat
  );

endinterface

// File: rtl/hpf_mac_rs.sv
// hpf_mac_rs: combinational multiply -> round-half-up -> saturate.
//   t     : signed accumulator value (WIDTH+2 bits)
//   alpha : unsigned Q-format gain, 0..2^SCALE
//   y     : clipped signed result
//   sat   : result was clipped
module hpf_mac_rs
  import hpf_pkg::*;
#(
  parameter int unsigned WIDTH = HPF_WIDTH,
  parameter int unsigned SCALE = HPF_SCALE
) (
  input  logic signed [WIDTH+1:0] t,
  input  logic [SCALE:0]          alpha,
  output logic signed [WIDTH-1:0] y,
  output logic                    sat
);

  logic signed [63:0] t_ext;
  logic signed [63:0] a_ext;
  logic signed [63:0] prod;
  sat_res_t           res;

  always_comb begin
    t_ext = 64'(t);                    // sign-extends
    a_ext = $signed(64'(alpha));       // zero-extends, alpha is unsigned
    prod  = t_ext * a_ext;
    res   = sat_round(prod, WIDTH, SCALE);
    y     = res.y[WIDTH-1:0];
    sat   = res.sat;
  end

endmodule

// File: rtl/hpf_tdm.sv
// hpf_tdm: time-multiplexed multi-channel first-order IIR high-pass filter,
//   y[n] = alpha * (y[n-1] + x[n] - x[n-1]), two-stage pipeline, one shared multiplier.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : hpf_tdm_if slave (input stream, config, clear, output stream)
module hpf_tdm
  import hpf_pkg::*;
#(
  parameter int unsigned WIDTH     = HPF_WIDTH,
  parameter int unsigned SCALE     = HPF_SCALE,
  parameter int unsigned CHANNELS  = HPF_CHANNELS,
  parameter int unsigned ALPHA_RST = HPF_ALPHA_RST
) (
  input logic        clk,
  input logic        rst,
  hpf_tdm_if.slave   bus
);

  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned ACCW = WIDTH + 2;

  logic signed [WIDTH-1:0] x_prev [CHANNELS];
  logic signed [WIDTH-1:0] y_prev [CHANNELS];

  // Stage 1 registers.
  logic                    s1_valid;
  logic [CH_W-1:0]         s1_ch;
  logic signed [WIDTH-1:0] s1_x;
  logic [SCALE:0]          s1_alpha;
  logic                    s1_bypass;
  logic signed [ACCW-1:0]  s1_t;

  logic                    adv;
  logic                    accept;
  logic                    in_range;
  logic                    retire;
  logic                    fwd;
  logic [CH_W-1:0]         ch_idx;
  logic signed [WIDTH-1:0] y_src;
  logic signed [WIDTH-1:0] y_ret;
  logic signed [ACCW-1:0]  t_d;
  logic signed [WIDTH-1:0] mac_y;
  logic                    mac_sat;

  hpf_mac_rs #(
    .WIDTH (WIDTH),
    .SCALE (SCALE)
  ) u_mac (
    .t     (s1_t),
    .alpha (s1_alpha),
    .y     (mac_y),
    .sat   (mac_sat)
  );

  always_comb begin
    adv         = !bus.m_valid || bus.m_ready;
    bus.s_ready = adv;
    accept      = bus.s_valid && adv;
    in_range    = int'(bus.s_ch) < int'(CHANNELS);
    ch_idx      = in_range ? bus.s_ch : '0;
    retire      = s1_valid && adv;
    // Value stage 1 writes into y_prev when it retires; bypass restarts the channel at zero.
    y_ret       = s1_bypass ? '0 : mac_y;
    // A clear on the incoming channel suppresses forwarding for that cycle.
    fwd         = s1_valid && (s1_ch == bus.s_ch) &&
                  !(bus.clr_valid && (bus.clr_ch == bus.s_ch));
    y_src       = fwd ? y_ret : y_prev[ch_idx];
    t_d         = ACCW'(y_src) + ACCW'(bus.s_data) - ACCW'(x_prev[ch_idx]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        x_prev[i] <= '0;
        y_prev[i] <= '0;
      end
      s1_valid    <= 1'b0;
      bus.m_valid <= 1'b0;
      bus.m_ch    <= '0;
      bus.m_data  <= '0;
      bus.m_sat   <= 1'b0;
    end else begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (retire && (s1_ch == CH_W'(i))) begin
          y_prev[i] <= y_ret;
        end
        if (accept && in_range && (bus.s_ch == CH_W'(i))) begin
          x_prev[i] <= bus.s_data;
        end
        // Clear is last so it overrides any same-cycle write to the channel.
        if (bus.clr_valid && (bus.clr_ch == CH_W'(i))) begin
          x_prev[i] <= '0;
          y_prev[i] <= '0;
        end
      end
      if (adv) begin
        s1_valid  <= accept && in_range;
        s1_ch     <= bus.s_ch;
        s1_x      <= bus.s_data;
        s1_alpha  <= bus.cfg_alpha;
        s1_bypass <= bus.cfg_bypass;
        s1_t      <= t_d;
        bus.m_valid <= retire;
        if (retire) begin
          bus.m_ch   <= s1_ch;
          bus.m_data <= s1_bypass ? s1_x : mac_y;
          bus.m_sat  <= s1_bypass ? 1'b0 : mac_sat;
        end
      end
    end
  end

endmodule

// File: doc/hpf_tdm.md
Name: hpf_tdm

Overview:
Time-multiplexed, multi-channel first-order IIR high-pass filter for the pre-processing chain: y[n] = alpha·(y[n-1] + x[n] − x[n-1]), Q-format alpha, round-half-up, saturating output.
All channels share one multiplier. Per-channel state is held in register arrays. Valid/ready streaming on both sides with a channel tag.
Adds over the single-channel filter: channel count, runtime alpha, bypass, per-channel clear, saturation flag and backpressure.

Parameters:
WIDTH, 10, signed sample width (in and out)
SCALE, 15, fractional bits of alpha
CHANNELS, 4, number of interleaved channels (≥1); CH_W = max(1, clog2(CHANNELS)) is derived, not overridable
ALPHA_RST, 30831, not used by datapath; documents the recommended cfg_alpha (≈0.9409)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
s_valid  in  1  input sample valid
s_ready  out  1  block can accept
s_ch  in  CH_W  channel of input sample; values ≥CHANNELS are ignored (sample accepted and dropped, no output)
s_data  in  WIDTH  signed input sample
cfg_alpha  in  SCALE+1  unsigned alpha, 0..2^SCALE (2^SCALE = 1.0); captured per sample at accept
cfg_bypass  in  1  captured per sample at accept; output = input
clr_valid  in  1  clear request
clr_ch  in  CH_W  channel whose state is zeroed
m_valid  out  1  output valid
m_ready  in  1  downstream ready
m_ch  out  CH_W  channel tag of output
m_data  out  WIDTH  signed filtered sample
m_sat  out  1  output was clipped

Behaviour:
- Reset (clk edge with rst=1): x_prev[], y_prev[] = 0; stage-1 valid = 0; m_valid = 0; m_ch, m_data, m_sat = 0. Reset mid-stream discards in-flight samples.
- Advance: adv = !m_valid || m_ready. s_ready = adv. Accept = s_valid && s_ready. The pipeline moves only when adv = 1. m_* hold stable while m_valid && !m_ready.
- Latency: 2 cycles from accept to m_valid at full throughput (1 sample/cycle).
- Stage 1, at accept for channel c:
  - Register t = y_src + x − x_prev[c], computed in ACCW = WIDTH+2 signed bits (no overflow).
  - Also register c, x, alpha and bypass.
  - Write x_prev[c] <= x.
- Forwarding: if stage 1 holds a valid sample of the same channel c, y_src is that sample's result (the value being retired this cycle). Otherwise y_src = y_prev[c].
- Stage 2 (output register), when stage 1 retires:
  - p = t·alpha (signed × unsigned, ACCW+SCALE+1 bits).
  - r = (p + 2^(SCALE-1)) >>> SCALE, arithmetic shift.
  - Clip r to [−2^(WIDTH-1), 2^(WIDTH-1)−1]. m_sat = 1 iff clipped.
  - Write y_prev[c] <= clipped y.
- Bypass: m_data = x, m_sat = 0. State update is x_prev <= x and y_prev <= 0, so the filter restarts clean when bypass is removed.
- Clear: zeroes x_prev[clr_ch] and y_prev[clr_ch]. It overrides any same-cycle state write to that channel, and forwarding for that channel is suppressed that cycle. A sample already in stage 1 still retires and produces output, and writes y_prev only if it retires after the clear cycle.
- alpha = 0: output 0. alpha = 2^SCALE: no attenuation, saturation possible.

Decomposition:
- Package hpf_pkg holds:
  - ACCW and product-width constants
  - ALPHA_ONE = 2^SCALE
  - MAX/MIN sample constants
  - function sat_round (round-half-up plus clip, returns value and flag)
- Sub-module hpf_mac_rs: combinational multiply → round → saturate, instantiated once in stage 2.

Test Plan:
1. Step, ch0, alpha=30831: x = 0, 100, 100 with m_ready=1 → m_data = 0, 94, 88. Back-to-back accepts exercise forwarding.
2. Interleave, alpha=30831: ch0=100, ch1=−100, ch0=100, ch1=−100 → 94, −94, 88, −88, with m_ch tags 0, 1, 0, 1.
3. Saturation, ch2: x=−512 with alpha=16384 → −256. Then x=511 with alpha=32768 → m_data=511, m_sat=1.
4. Backpressure: m_ready=0 for 5 cycles with s_valid=1 → exactly 2 samples accepted, s_ready=0, m_data stable. Release → all outputs in order, none lost or duplicated.
5. Bypass/clear: bypass ch3 x=−300 → −300, m_sat=0. Next, non-bypass x=−300, alpha=32768 → 0. Clear ch0 after case 1, then x=100 → 94.
6. Reset mid-stream: rst for 1 cycle while m_valid=1 and stage 1 is full → next cycle m_valid=0 and s_ready=1. Then ch0 x=100 → 94.
